// File: rtl/ex_mem_stage.sv
// EX/MEM boundary: resolves branches/jumps, issues a one-cycle redirect, latches EX/MEM fields.
// Latency 1 cycle; STALL freezes all state except the REDIRECT/MISALIGN_EXC pulses, which drop.
// Optional BRANCH_MISALIGN_TRAP_EN: taken targets with bit 1 set raise MISALIGN_EXC instead of redirecting.
module ex_mem_stage (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        VALID_IN,
    input  logic [31:0] ALU_RESULT,
    input  logic        EQUAL,
    input  logic        SIGNEDLT,
    input  logic        UNSIGNEDLT,
    input  logic [31:0] PC,
    input  logic [31:0] IMM,
    input  logic [31:0] RS2_DATA,
    input  logic [4:0]  RD_ADDR,
    input  logic [2:0]  FUNCT3,
    input  logic        BRANCH,
    input  logic        JAL,
    input  logic        JALR,
    input  logic        REG_WRITE,
    input  logic        MEM_READ,
    input  logic        MEM_WRITE,
    output logic        VALID_OUT,
    output logic [31:0] RESULT_OUT,
    output logic [31:0] STORE_DATA_OUT,
    output logic [4:0]  RD_OUT,
    output logic [2:0]  FUNCT3_OUT,
    output logic        REG_WRITE_OUT,
    output logic        MEM_READ_OUT,
    output logic        MEM_WRITE_OUT,
    output logic        REDIRECT,
    output logic [31:0] TARGET,
    output logic        MISALIGN_EXC
);

    logic        r_squash;
    logic        r_valid;
    logic [31:0] r_result;
    logic [31:0] r_store;
    logic [4:0]  r_rd;
    logic [2:0]  r_funct3;
    logic        r_reg_write;
    logic        r_mem_read;
    logic        r_mem_write;
    logic        r_redirect;
    logic [31:0] r_target;

    logic        w_accept;
    logic        w_cond;
    logic        w_taken;
    logic        w_mis;
    logic [31:0] w_target;

    // The instruction in EX right after a taken redirect is wrong-path and never accepted.
    assign w_accept = VALID_IN & ~STALL & ~r_squash;

    always_comb begin
        w_cond = 1'b0;
        case (FUNCT3)
            3'b000:  w_cond = EQUAL;
            3'b001:  w_cond = ~EQUAL;
            3'b100:  w_cond = SIGNEDLT;
            3'b101:  w_cond = ~SIGNEDLT;
            3'b110:  w_cond = UNSIGNEDLT;
            3'b111:  w_cond = ~UNSIGNEDLT;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_taken  = w_accept & (JAL | JALR | (BRANCH & w_cond));
    assign w_target = JALR ? {ALU_RESULT[31:1], 1'b0} : (PC + IMM);

`ifdef BRANCH_MISALIGN_TRAP_EN
    logic r_misalign;
    assign w_mis        = w_taken & w_target[1];
    assign MISALIGN_EXC = r_misalign;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            r_misalign <= 1'b0;
        else
            r_misalign <= ~STALL & w_mis;
    end
`else
    assign w_mis        = 1'b0;
    assign MISALIGN_EXC = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_squash    <= 1'b0;
            r_valid     <= 1'b0;
            r_result    <= 32'd0;
            r_store     <= 32'd0;
            r_rd        <= 5'd0;
            r_funct3    <= 3'd0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_redirect  <= 1'b0;
            r_target    <= 32'd0;
        end else if (STALL) begin
            r_redirect  <= 1'b0;
        end else begin
            r_redirect <= w_taken & ~w_mis;
            r_squash   <= w_taken & ~w_mis;
            if (w_taken)
                r_target <= w_target;
            r_valid <= w_accept;
            if (w_accept) begin
                r_result    <= (JAL | JALR) ? (PC + 32'd4) : ALU_RESULT;
                r_store     <= RS2_DATA;
                r_rd        <= RD_ADDR;
                r_funct3    <= FUNCT3;
                r_reg_write <= REG_WRITE & ~w_mis;
                r_mem_read  <= MEM_READ;
                r_mem_write <= MEM_WRITE;
            end else begin
                r_reg_write <= 1'b0;
                r_mem_read  <= 1'b0;
                r_mem_write <= 1'b0;
            end
        end
    end

    assign VALID_OUT      = r_valid;
    assign RESULT_OUT     = r_result;
    assign STORE_DATA_OUT = r_store;
    assign RD_OUT         = r_rd;
    assign FUNCT3_OUT     = r_funct3;
    assign REG_WRITE_OUT  = r_reg_write;
    assign MEM_READ_OUT   = r_mem_read;
    assign MEM_WRITE_OUT  = r_mem_write;
    assign REDIRECT       = r_redirect;
    assign TARGET         = r_target;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: directed plan cases plus random traffic against an ISA-level model.
module tb_ex_mem_stage;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        STALL, VALID_IN, EQUAL, SIGNEDLT, UNSIGNEDLT;
    logic [31:0] ALU_RESULT, PC, IMM, RS2_DATA;
    logic [4:0]  RD_ADDR;
    logic [2:0]  FUNCT3;
    logic        BRANCH, JAL, JALR, REG_WRITE, MEM_READ, MEM_WRITE;
    logic        VALID_OUT, REG_WRITE_OUT, MEM_READ_OUT, MEM_WRITE_OUT, REDIRECT, MISALIGN_EXC;
    logic [31:0] RESULT_OUT, STORE_DATA_OUT, TARGET;
    logic [4:0]  RD_OUT;
    logic [2:0]  FUNCT3_OUT;

    ex_mem_stage dut (
        .CLK(CLK), .RESET(RESET), .STALL(STALL), .VALID_IN(VALID_IN),
        .ALU_RESULT(ALU_RESULT), .EQUAL(EQUAL), .SIGNEDLT(SIGNEDLT), .UNSIGNEDLT(UNSIGNEDLT),
        .PC(PC), .IMM(IMM), .RS2_DATA(RS2_DATA), .RD_ADDR(RD_ADDR), .FUNCT3(FUNCT3),
        .BRANCH(BRANCH), .JAL(JAL), .JALR(JALR), .REG_WRITE(REG_WRITE),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .VALID_OUT(VALID_OUT), .RESULT_OUT(RESULT_OUT), .STORE_DATA_OUT(STORE_DATA_OUT),
        .RD_OUT(RD_OUT), .FUNCT3_OUT(FUNCT3_OUT), .REG_WRITE_OUT(REG_WRITE_OUT),
        .MEM_READ_OUT(MEM_READ_OUT), .MEM_WRITE_OUT(MEM_WRITE_OUT),
        .REDIRECT(REDIRECT), .TARGET(TARGET), .MISALIGN_EXC(MISALIGN_EXC)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        stall, vld;
        logic [31:0] a, b;       // branch operands; flags are derived from these
        logic [31:0] alu, pc, imm, rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        br, jal, jalr, rw, mr, mw;
    } in_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] result, store;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        rw, mr, mw, redirect;
        logic [31:0] target;
        logic        misalign;
    } exp_t;

    exp_t m;
    logic m_sq;
    exp_t q[$];
    int   n_chk = 0, n_pass = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic br_taken(in_t t);
        case (t.f3)
            3'd0: return t.a == t.b;
            3'd1: return t.a != t.b;
            3'd4: return $signed(t.a) <  $signed(t.b);
            3'd5: return $signed(t.a) >= $signed(t.b);
            3'd6: return t.a <  t.b;
            3'd7: return t.a >= t.b;
            default: return 1'b0;
        endcase
    endfunction

    // Architectural reference: what EX/MEM should hold after one edge with inputs t.
    function automatic void model_step(in_t t);
        logic acc, tk, mis;
        logic [31:0] tgt;
        if (t.stall) begin
            m.redirect = 1'b0;
            m.misalign = 1'b0;
            return;
        end
        acc = t.vld && !m_sq;
        tk  = acc && (t.jal || t.jalr || (t.br && br_taken(t)));
        tgt = t.jalr ? (t.alu & 32'hFFFF_FFFE) : (t.pc + t.imm);
`ifdef BRANCH_MISALIGN_TRAP_EN
        mis = tk && tgt[1];
`else
        mis = 1'b0;
`endif
        m.redirect = tk && !mis;
        m.misalign = mis;
        if (tk) m.target = tgt;
        m_sq    = tk && !mis;
        m.valid = acc;
        if (acc) begin
            m.result = (t.jal || t.jalr) ? t.pc + 32'd4 : t.alu;
            m.store  = t.rs2;
            m.rd     = t.rd;
            m.f3     = t.f3;
            m.rw     = t.rw && !mis;
            m.mr     = t.mr;
            m.mw     = t.mw;
        end else begin
            m.rw = 1'b0; m.mr = 1'b0; m.mw = 1'b0;
        end
    endfunction

    task automatic drive(in_t t);
        @(negedge CLK);
        RESET      = 1'b0;
        STALL      = t.stall;   VALID_IN  = t.vld;
        ALU_RESULT = t.alu;     PC        = t.pc;     IMM = t.imm;  RS2_DATA = t.rs2;
        EQUAL      = (t.a == t.b);
        SIGNEDLT   = ($signed(t.a) < $signed(t.b));
        UNSIGNEDLT = (t.a < t.b);
        RD_ADDR    = t.rd;      FUNCT3    = t.f3;
        BRANCH     = t.br;      JAL       = t.jal;    JALR = t.jalr;
        REG_WRITE  = t.rw;      MEM_READ  = t.mr;     MEM_WRITE = t.mw;
        model_step(t);
        q.push_back(m);
    endtask

    function automatic in_t alu_op(logic [31:0] res, logic [4:0] rd);
        in_t t = '0;
        t.vld = 1'b1; t.alu = res; t.rd = rd; t.rw = 1'b1; t.rs2 = $urandom;
        return t;
    endfunction

    function automatic in_t branch(logic [2:0] f3, logic [31:0] a, logic [31:0] b,
                                   logic [31:0] pc, logic [31:0] imm);
        in_t t = '0;
        t.vld = 1'b1; t.br = 1'b1; t.f3 = f3; t.a = a; t.b = b;
        t.alu = a - b; t.pc = pc; t.imm = imm;
        return t;
    endfunction

    task automatic settle;
        @(posedge CLK);
        #2;
    endtask

    // Monitor: every edge the DUT presents a new EX/MEM state, checked against the queue head.
    initial begin
        exp_t e, act;
        forever begin
            @(posedge CLK);
            #1;
            if (q.size() != 0) begin
                e   = q.pop_front();
                act = '{VALID_OUT, RESULT_OUT, STORE_DATA_OUT, RD_OUT, FUNCT3_OUT,
                        REG_WRITE_OUT, MEM_READ_OUT, MEM_WRITE_OUT, REDIRECT, TARGET, MISALIGN_EXC};
                n_chk++;
                if (act === e) n_pass++;
                else $display("FAIL scoreboard @%0t: got %h expected %h", $time, act, e);
            end
        end
    end

    initial begin
        in_t t;
        int  kind;
        RESET = 1'b1; STALL = 0; VALID_IN = 0; ALU_RESULT = 0; PC = 0; IMM = 0; RS2_DATA = 0;
        EQUAL = 0; SIGNEDLT = 0; UNSIGNEDLT = 0; RD_ADDR = 0; FUNCT3 = 0;
        BRANCH = 0; JAL = 0; JALR = 0; REG_WRITE = 0; MEM_READ = 0; MEM_WRITE = 0;
        m = '0; m_sq = 1'b0;
        #12;
        chk("reset_valid", {31'd0, VALID_OUT}, 32'd0);
        chk("reset_target", TARGET, 32'd0);
        chk("reset_redirect", {31'd0, REDIRECT}, 32'd0);

        // BEQ taken, then the wrong-path instruction is dropped
        drive(branch(3'd0, 32'd5, 32'd5, 32'h100, 32'h20));
        settle;
        chk("beq_redirect", {31'd0, REDIRECT}, 32'd1);
        chk("beq_target", TARGET, 32'h120);
        chk("beq_valid", {31'd0, VALID_OUT}, 32'd1);
        chk("beq_regwrite", {31'd0, REG_WRITE_OUT}, 32'd0);
        drive(alu_op(32'hDEAD, 5'd3));
        settle;
        chk("beq_shadow_dropped", {31'd0, VALID_OUT}, 32'd0);

        // BLTU not taken, next instruction accepted back-to-back
        drive(branch(3'd6, 32'd10, 32'd3, 32'h200, 32'h40));
        settle;
        chk("bltu_no_redirect", {31'd0, REDIRECT}, 32'd0);
        drive(alu_op(32'h1234, 5'd4));
        settle;
        chk("bltu_next_valid", {31'd0, VALID_OUT}, 32'd1);
        chk("bltu_next_result", RESULT_OUT, 32'h1234);

        // JALR with target bit 1 set
        t = '0; t.vld = 1; t.jalr = 1; t.alu = 32'h2003; t.pc = 32'h40; t.rd = 5'd1; t.rw = 1;
        drive(t);
        settle;
        chk("jalr_target", TARGET, 32'h2002);
        chk("jalr_result", RESULT_OUT, 32'h44);
`ifdef BRANCH_MISALIGN_TRAP_EN
        chk("jalr_misalign", {31'd0, MISALIGN_EXC}, 32'd1);
        chk("jalr_no_redirect", {31'd0, REDIRECT}, 32'd0);
`else
        chk("jalr_regwrite", {31'd0, REG_WRITE_OUT}, 32'd1);
        chk("jalr_redirect", {31'd0, REDIRECT}, 32'd1);
`endif
        drive(alu_op(32'h55, 5'd6));
        settle;

        // Taken JAL followed by three stall cycles
        t = '0; t.vld = 1; t.jal = 1; t.pc = 32'h200; t.imm = 32'h40; t.rd = 5'd1; t.rw = 1;
        drive(t);
        settle;
        chk("jal_redirect", {31'd0, REDIRECT}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            t = alu_op(32'h77 + i, 5'd7); t.stall = 1;
            drive(t);
            settle;
            chk("stall_redirect_low", {31'd0, REDIRECT}, 32'd0);
            chk("stall_result_hold", RESULT_OUT, 32'h204);
        end
        drive(alu_op(32'h88, 5'd8));
        settle;
        chk("post_stall_dropped", {31'd0, VALID_OUT}, 32'd0);
        drive(alu_op(32'h99, 5'd9));
        settle;
        chk("post_stall_accepted", RESULT_OUT, 32'h99);

        // BNE taken with wrap-around target
        drive(branch(3'd1, 32'd1, 32'd2, 32'hFFFF_FFF0, 32'h20));
        settle;
        chk("wrap_target", TARGET, 32'h10);
        drive(alu_op(32'h1, 5'd1));

        // Asynchronous reset while a redirect is pending
        t = '0; t.vld = 1; t.jal = 1; t.pc = 32'h300; t.imm = 32'h8; t.rd = 5'd2; t.rw = 1;
        drive(t);
        @(posedge CLK);
        #3;
        chk("pre_reset_redirect", {31'd0, REDIRECT}, 32'd1);
        RESET = 1'b1;
        #1;
        chk("async_reset_redirect", {31'd0, REDIRECT}, 32'd0);
        chk("async_reset_valid", {31'd0, VALID_OUT}, 32'd0);
        chk("async_reset_target", TARGET, 32'd0);
        chk("async_reset_result", RESULT_OUT, 32'd0);
        m = '0; m_sq = 1'b0;
        drive(alu_op(32'hABC, 5'd10));
        settle;
        chk("post_reset_accepted", {31'd0, VALID_OUT}, 32'd1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            kind = $urandom_range(0, 5);
            case (kind)
                0: t = alu_op($urandom, 5'($urandom));
                1: begin t = alu_op($urandom, 5'($urandom)); t.mr = 1; t.f3 = 3'($urandom_range(0, 5)); end
                2: begin t = alu_op($urandom, 5'($urandom)); t.rw = 0; t.mw = 1; t.f3 = 3'($urandom_range(0, 2)); end
                3: begin
                    t = branch(3'($urandom), $urandom, $urandom, $urandom & 32'hFFFF_FFFC,
                               $urandom & 32'hFFFF_FFFE);
                    if ($urandom_range(0, 2) == 0) begin t.b = t.a; t.alu = 32'd0; end
                end
                4: begin t = alu_op($urandom, 5'($urandom)); t.jal = 1;
                          t.pc = $urandom & 32'hFFFF_FFFC; t.imm = $urandom & 32'hFFFF_FFFE; end
                default: begin t = alu_op($urandom, 5'($urandom)); t.jalr = 1;
                          t.pc = $urandom & 32'hFFFF_FFFC; end
            endcase
            t.vld   = ($urandom_range(0, 9) != 0);
            t.stall = ($urandom_range(0, 3) == 0);
            drive(t);
        end

        repeat (3) @(posedge CLK);
        #2;
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
